// File: rtl/ustc_line_pack_pkg.sv
// ustc_pkg: shared sizes, FSM states, ctrl bit positions and the lane-pack helper.
package ustc_pkg;
  localparam int M = 16;
  localparam int NUM_IN = 32;
  localparam int DW_DATA = 8;
  localparam int DW_ROW = 4;
  localparam int DW_COL = 4;
  localparam int DW_CTRL = 4;
  localparam int DW_LINE = DW_DATA + DW_ROW + DW_CTRL;
  localparam int DRAIN_CYC = M + 3;
  localparam int DW_CNT = $clog2(DRAIN_CYC + 1);
  localparam int CTRL_VALID = DW_CTRL - 2;
  localparam int CTRL_LAST = DW_CTRL - 1;
  typedef enum logic [1:0] {IDLE, PACK, FLUSH, DRAIN} state_e;
  function automatic logic [DW_LINE-1:0] pack_lane(input logic vld, input logic last,
                                                   input logic [DW_ROW-1:0] row,
                                                   input logic [DW_DATA-1:0] data);
    logic [DW_CTRL-1:0] ctrl;
    ctrl = '0;
    ctrl[CTRL_VALID] = 1'b1;
    ctrl[CTRL_LAST] = last;
    return vld ? {ctrl, row, data} : '0;
  endfunction
endpackage

// File: rtl/ustc_line_pack_if.sv
// ustc_line_pack_if: column input handshake plus packed-line output bundle.
interface ustc_line_pack_if import ustc_pkg::*; #(parameter int LANES = NUM_IN);
  logic in_valid, in_ready, in_last, out_en;
  logic [DW_COL-1:0] in_col, col;
  logic [M*DW_DATA-1:0] in_data;
  logic [LANES*DW_LINE-1:0] line;
  modport master (output in_valid, in_col, in_data, in_last, input in_ready, col, line, out_en);
  modport slave (input in_valid, in_col, in_data, in_last, output in_ready, col, line, out_en);
endinterface

// File: rtl/ustc_line_pack_select.sv
// ustc_pack_select: picks the LANES lowest-index set mask bits via prefix counts.
module ustc_pack_select import ustc_pkg::*; #(parameter int LANES = NUM_IN) (
  input  logic [M-1:0] mask_i,
  output logic [LANES-1:0][DW_ROW-1:0] rows_o,
  output logic [LANES-1:0] vld_o,
  output logic [M-1:0] sent_o
);
  int pc [M];
  always_comb begin
    pc[0] = 0;
    for (int r = 1; r < M; r++) pc[r] = pc[r-1] + int'(mask_i[r-1]);
    rows_o = '0;
    vld_o = '0;
    for (int r = 0; r < M; r++) sent_o[r] = mask_i[r] && (pc[r] < LANES);
    for (int g = 0; g < LANES; g++)
      for (int r = 0; r < M; r++)
        if (mask_i[r] && pc[r] == g) begin
          rows_o[g] = DW_ROW'(r);
          vld_o[g] = 1'b1;
        end
  end
endmodule

// File: rtl/ustc_line_pack.sv
// ustc_line_pack: sparse column -> {ctrl,row,data} line packer; USTC_PACK_ZERO_SKIP_EN drops empty-column beats.
module ustc_line_pack import ustc_pkg::*; #(parameter int LANES = NUM_IN) (
  input logic clk,
  input logic rst_n,
  ustc_line_pack_if.slave bus
);
  state_e state_q, state_d;
  logic alive_q;
  logic [M-1:0] mask_q, mask_d, nz, sent;
  logic [M-1:0][DW_DATA-1:0] data_q, data_d, in_el;
  logic last_q, last_d, out_en_q, out_en_d, done, emit;
  logic [DW_COL-1:0] ccol_q, ccol_d, col_q, col_d;
  logic [LANES-1:0][DW_LINE-1:0] line_q, line_d;
  logic [DW_CNT-1:0] cnt_q, cnt_d;
  logic [LANES-1:0][DW_ROW-1:0] rows;
  logic [LANES-1:0] vld;

  ustc_pack_select #(.LANES(LANES)) u_sel (.mask_i(mask_q), .rows_o(rows), .vld_o(vld), .sent_o(sent));

  assign in_el = bus.in_data;
  assign done = ~|(mask_q & ~sent);
`ifdef USTC_PACK_ZERO_SKIP_EN
  assign emit = |mask_q;
`else
  assign emit = 1'b1;
`endif
  // alive_q keeps in_ready low until the first edge after reset release
  assign bus.in_ready = alive_q && state_q == IDLE;
  assign bus.col = col_q;
  assign bus.line = line_q;
  assign bus.out_en = out_en_q;

  always_comb
    for (int r = 0; r < M; r++) nz[r] = |in_el[r];

  always_comb begin
    state_d = state_q;
    mask_d = mask_q;
    data_d = data_q;
    last_d = last_q;
    ccol_d = ccol_q;
    col_d = col_q;
    line_d = '0;
    out_en_d = 1'b0;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: if (bus.in_valid && alive_q) begin
        mask_d = nz;
        data_d = in_el;
        last_d = bus.in_last;
        ccol_d = bus.in_col;
        state_d = PACK;
      end
      PACK: begin
        for (int g = 0; g < LANES; g++) line_d[g] = pack_lane(vld[g], done, rows[g], data_q[rows[g]]);
        col_d = emit ? ccol_q : col_q;
        mask_d = mask_q & ~sent;
        state_d = done ? (last_q ? FLUSH : IDLE) : PACK;
      end
      FLUSH: begin
        out_en_d = 1'b1;
        cnt_d = DW_CNT'(DRAIN_CYC);
        state_d = DRAIN;
      end
      default: begin
        cnt_d = cnt_q == '0 ? cnt_q : cnt_q - DW_CNT'(1);
        state_d = cnt_q == '0 ? IDLE : DRAIN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      alive_q <= 1'b0;
      mask_q <= '0;
      data_q <= '0;
      last_q <= 1'b0;
      ccol_q <= '0;
      col_q <= '0;
      line_q <= '0;
      out_en_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      alive_q <= 1'b1;
      mask_q <= mask_d;
      data_q <= data_d;
      last_q <= last_d;
      ccol_q <= ccol_d;
      col_q <= col_d;
      line_q <= line_d;
      out_en_q <= out_en_d;
      cnt_q <= cnt_d;
    end
endmodule

// File: tb/tb_ustc_line_pack.sv
// tb_ustc_line_pack: directed table plus corner sequences for 32-lane and 8-lane packers.
module tb_ustc_line_pack;
  import ustc_pkg::*;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ustc_line_pack_if #(.LANES(32)) b();
  ustc_line_pack_if #(.LANES(8)) b8();
  ustc_line_pack #(.LANES(32)) dut (.clk(clk), .rst_n(rst_n), .bus(b));
  ustc_line_pack #(.LANES(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8));

  int errs = 0, checks = 0;
  int acc [16][16];
  int gold [16][16];
  logic acc_on = 1'b0;

  typedef struct { logic [3:0] c; logic [127:0] d; logic [3:0] ecol; } vec_t;
  vec_t tv [5];
  logic [127:0] d, dfull;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic send(input logic [3:0] c, input logic [127:0] dd, input logic l);
    int n = 0;
    b.in_valid = 1'b1; b.in_col = c; b.in_data = dd; b.in_last = l;
    @(negedge clk);
    while (!b.in_ready && n < 100) begin @(negedge clk); n++; end
    if (!b.in_ready) chk("send timeout", 0, 1);
    @(posedge clk); #1;
    b.in_valid = 1'b0;
  endtask

  task automatic send8(input logic [3:0] c, input logic [127:0] dd);
    int n = 0;
    b8.in_valid = 1'b1; b8.in_col = c; b8.in_data = dd; b8.in_last = 1'b0;
    @(negedge clk);
    while (!b8.in_ready && n < 100) begin @(negedge clk); n++; end
    if (!b8.in_ready) chk("send8 timeout", 0, 1);
    @(posedge clk); #1;
    b8.in_valid = 1'b0;
  endtask

  function automatic logic [511:0] exp_line(input logic [127:0] dd, input int lanes, input int beat);
    logic [511:0] l = '0;
    int k = 0, nnz = 0;
    logic last;
    for (int r = 0; r < 16; r++) if (dd[r*8 +: 8] != 0) nnz++;
    last = nnz <= (beat + 1) * lanes;
    for (int r = 0; r < 16; r++)
      if (dd[r*8 +: 8] != 0) begin
        if (k >= beat * lanes && k < (beat + 1) * lanes)
          l[(k - beat * lanes) * 16 +: 16] = {last, 1'b1, 2'b00, 4'(r), dd[r*8 +: 8]};
        k++;
      end
    return l;
  endfunction

  function automatic logic any_valid(input logic [511:0] l);
    logic v = 1'b0;
    for (int g = 0; g < 32; g++) v |= l[g*16 + 14];
    return v;
  endfunction

  always @(negedge clk)
    if (acc_on) begin
      for (int g = 0; g < 32; g++)
        if (b.line[g*16 + 14]) acc[b.col][b.line[g*16 + 8 +: 4]] += int'(b.line[g*16 +: 8]);
      if (b.in_valid && b.in_ready)
        for (int r = 0; r < 16; r++) gold[b.in_col][r] += int'(b.in_data[r*8 +: 8]);
    end

  initial begin
    rst_n = 1'b0;
    b.in_valid = 1'b0; b.in_col = '0; b.in_data = '0; b.in_last = 1'b0;
    b8.in_valid = 1'b0; b8.in_col = '0; b8.in_data = '0; b8.in_last = 1'b0;
    d = '0; d[7:0] = 8'h01; d[5*8 +: 8] = 8'h7F; d[15*8 +: 8] = 8'h80;
    tv[0] = '{4'd3, d, 4'd3};
    for (int r = 0; r < 16; r++) d[r*8 +: 8] = 8'(r + 1);
    tv[1] = '{4'd10, d, 4'd10};
    d = '0; d[7*8 +: 8] = 8'hFF;
    tv[2] = '{4'd0, d, 4'd0};
    d = '0;
    for (int r = 1; r < 16; r += 2) d[r*8 +: 8] = 8'hA0 + 8'(r);
    tv[3] = '{4'd15, d, 4'd15};
`ifdef USTC_PACK_ZERO_SKIP_EN
    tv[4] = '{4'd5, 128'h0, 4'd15};
`else
    tv[4] = '{4'd5, 128'h0, 4'd5};
`endif
    for (int r = 0; r < 16; r++) dfull[r*8 +: 8] = 8'h10 + 8'(r);

    repeat (2) @(negedge clk);
    chk("reset in_ready", b.in_ready, 0);
    chk("reset line", b.line, 0);
    chk("reset col", b.col, 0);
    chk("reset out_en", b.out_en, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready after release", b.in_ready, 1);

    for (int i = 0; i < 5; i++) begin
      send(tv[i].c, tv[i].d, 1'b0);
      @(negedge clk); @(negedge clk);
      chk($sformatf("v%0d line", i), b.line, exp_line(tv[i].d, 32, 0));
      chk($sformatf("v%0d col", i), b.col, tv[i].ecol);
      chk($sformatf("v%0d out_en", i), b.out_en, 0);
      chk($sformatf("v%0d ready", i), b.in_ready, 1);
      if (i == 0) begin
        chk("v0 lane0", b.line[15:0], 16'hC001);
        chk("v0 lane1", b.line[31:16], 16'hC57F);
        chk("v0 lane2", b.line[47:32], 16'hCF80);
        chk("v0 upper lanes", b.line[511:48], 0);
      end
      @(negedge clk);
      chk($sformatf("v%0d idle line", i), b.line, 0);
    end

    d = '0; d[4*8 +: 8] = 8'h33;
    send(4'd2, d, 1'b1);
    @(negedge clk); @(negedge clk);
    chk("last beat line", b.line, 512'(16'hC433));
    chk("last beat out_en", b.out_en, 0);
    chk("last beat ready", b.in_ready, 0);
    @(negedge clk);
    chk("flush out_en", b.out_en, 1);
    chk("flush line", b.line, 0);
    chk("flush ready", b.in_ready, 0);
    begin
      int n = 0;
      @(negedge clk);
      chk("out_en one cycle", b.out_en, 0);
      while (!b.in_ready && n < 60) begin n++; @(negedge clk); end
      chk("drain low cycles", n, 19);
    end

    send8(4'd9, dfull);
    @(negedge clk); @(negedge clk);
    chk("b8 beat1 line", b8.line, exp_line(dfull, 8, 0));
    chk("b8 beat1 lane0", b8.line[15:0], 16'h4010);
    chk("b8 beat1 ready", b8.in_ready, 0);
    chk("b8 beat1 col", b8.col, 9);
    @(negedge clk);
    chk("b8 beat2 line", b8.line, exp_line(dfull, 8, 1));
    chk("b8 beat2 lane0", b8.line[15:0], 16'hC818);
    chk("b8 beat2 ready", b8.in_ready, 1);
    @(negedge clk);
    chk("b8 idle line", b8.line, 0);

    send8(4'd6, dfull);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midpack rst line", b8.line, 0);
    chk("midpack rst col", b8.col, 0);
    chk("midpack rst ready", b8.in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      logic seen = 1'b0;
      @(negedge clk);
      chk("midpack release ready", b8.in_ready, 1);
      repeat (4) begin seen |= any_valid(512'(b8.line)); @(negedge clk); end
      chk("midpack no old beats", seen, 0);
    end

    d = '0; d[8*8 +: 8] = 8'h44;
    send(4'd1, d, 1'b1);
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("middrain rst ready", b.in_ready, 0);
    chk("middrain rst col", b.col, 0);
    chk("middrain rst out_en", b.out_en, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("middrain release ready", b.in_ready, 1);

    for (int c = 0; c < 16; c++) for (int r = 0; r < 16; r++) begin acc[c][r] = 0; gold[c][r] = 0; end
    acc_on = 1'b1;
    for (int i = 0; i < 24; i++) begin
      d = '0;
      for (int r = 0; r < 16; r++) if ($urandom_range(0, 9) < 3) d[r*8 +: 8] = 8'($urandom_range(1, 255));
      send(4'($urandom_range(0, 15)), d, i % 8 == 7);
    end
    repeat (40) @(negedge clk);
    acc_on = 1'b0;
    for (int c = 0; c < 16; c++) begin
      logic [511:0] av = '0, gv = '0;
      for (int r = 0; r < 16; r++) begin av[r*32 +: 32] = acc[c][r]; gv[r*32 +: 32] = gold[c][r]; end
      chk($sformatf("accum col%0d", c), av, gv);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
